// File: rtl/prod_acc_16.sv
// prod_acc_16: burst accumulator behind the 16x16 multiplier's final adder.
// Define PROD_ACC_SAT_EN to make each addition saturate instead of wrapping.
module prod_acc_16 #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             abort_i,
  input  logic [15:0]      prod_i,
  input  logic             prod_valid_i,
  output logic             prod_ready_o,
  output logic [ACC_W-1:0] acc_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic             busy_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               prod_ready_q;
  logic               acc_valid_q;
  logic               busy_q;

  logic [ACC_W-1:0]   prod_ext_s;
  logic [ACC_W-1:0]   raw_sum_s;
  logic [ACC_W-1:0]   acc_d;
  logic               add_ovf_s;
  logic               accept_s;

  // Sign-extended sum of the running total and the incoming product.
  always_comb begin
    prod_ext_s = {{(ACC_W-16){prod_i[15]}}, prod_i};
    raw_sum_s  = acc_q + prod_ext_s;
    // Signed overflow: operands agree in sign but the result does not.
    add_ovf_s  = (acc_q[ACC_W-1] == prod_ext_s[ACC_W-1]) &&
                 (raw_sum_s[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef PROD_ACC_SAT_EN
    if (add_ovf_s) begin
      acc_d = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                             : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_d = raw_sum_s;
    end
`else
    acc_d = raw_sum_s;
`endif
    accept_s = prod_valid_i & prod_ready_q;
  end

  // Burst control FSM with registered handshake and status outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= {ACC_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      ovf_q        <= 1'b0;
      prod_ready_q <= 1'b0;
      acc_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else if (abort_i) begin
      // Abort wins over start and over a product arriving this cycle.
      state_q      <= ST_IDLE;
      acc_q        <= {ACC_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      ovf_q        <= 1'b0;
      prod_ready_q <= 1'b0;
      acc_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            acc_q  <= {ACC_W{1'b0}};
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (len_i == {CNT_W{1'b0}}) begin
              state_q     <= ST_DONE;
              acc_valid_q <= 1'b1;
            end else begin
              state_q      <= ST_ACC;
              cnt_q        <= len_i;
              prod_ready_q <= 1'b1;
            end
          end
        end
        ST_ACC: begin
          if (accept_s) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | add_ovf_s;
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_q      <= ST_DONE;
              prod_ready_q <= 1'b0;
              acc_valid_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (acc_ready_i) begin
            state_q     <= ST_IDLE;
            acc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          acc_q        <= {ACC_W{1'b0}};
          cnt_q        <= {CNT_W{1'b0}};
          ovf_q        <= 1'b0;
          prod_ready_q <= 1'b0;
          acc_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign prod_ready_o = prod_ready_q;
  assign acc_valid_o  = acc_valid_q;
  assign busy_o       = busy_q;
  assign ovf_o        = ovf_q;
  assign acc_o        = acc_q;

endmodule

// File: tb/tb_prod_acc_16.sv
// Self-checking bench for prod_acc_16: a 17-bit and a 24-bit instance share
// stimulus and are checked every cycle against an arithmetic burst model.
module tb_prod_acc_16;

  logic        sys_clk;
  logic        sys_rst;
  logic        start_i;
  logic [7:0]  len_i;
  logic        abort_i;
  logic [15:0] prod_i;
  logic        prod_valid_i;
  logic        acc_ready_i;

  logic        rdy17, vld17, busy17, ovf17;
  logic [16:0] acc17;
  logic        rdy24, vld24, busy24, ovf24;
  logic [23:0] acc24;

  int nerr = 0;
  int nchk = 0;
  bit chk_en = 1'b0;

  prod_acc_16 #(.ACC_W(17), .CNT_W(8)) dut17 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start_i(start_i), .len_i(len_i),
    .abort_i(abort_i), .prod_i(prod_i), .prod_valid_i(prod_valid_i),
    .prod_ready_o(rdy17), .acc_o(acc17), .acc_valid_o(vld17),
    .acc_ready_i(acc_ready_i), .busy_o(busy17), .ovf_o(ovf17)
  );

  prod_acc_16 #(.ACC_W(24), .CNT_W(8)) dut24 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start_i(start_i), .len_i(len_i),
    .abort_i(abort_i), .prod_i(prod_i), .prod_valid_i(prod_valid_i),
    .prod_ready_o(rdy24), .acc_o(acc24), .acc_valid_o(vld24),
    .acc_ready_i(acc_ready_i), .busy_o(busy24), .ovf_o(ovf24)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic longint hi_lim(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic bit ovf_of(input longint a, input longint p, input int w);
    longint s;
    s = a + p;
    return (s > hi_lim(w)) || (s < -hi_lim(w) - longint'(1));
  endfunction

  function automatic longint step(input longint a, input longint p, input int w);
    longint s;
    s = a + p;
    if (s > hi_lim(w)) begin
`ifdef PROD_ACC_SAT_EN
      s = hi_lim(w);
`else
      s = s - (longint'(1) <<< w);
`endif
    end else if (s < -hi_lim(w) - longint'(1)) begin
`ifdef PROD_ACC_SAT_EN
      s = -hi_lim(w) - longint'(1);
`else
      s = s + (longint'(1) <<< w);
`endif
    end
    return s;
  endfunction

  int     m_phase;  // 0 idle, 1 collecting products, 2 result waiting
  int     m_rem;
  longint m_sum17, m_sum24;
  bit     m_ovf17, m_ovf24;
  longint pv;

  assign pv = longint'($signed(prod_i));

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst || abort_i) begin
      m_phase <= 0; m_rem <= 0;
      m_sum17 <= 0; m_sum24 <= 0; m_ovf17 <= 1'b0; m_ovf24 <= 1'b0;
    end else if (m_phase == 0) begin
      if (start_i) begin
        m_sum17 <= 0; m_sum24 <= 0; m_ovf17 <= 1'b0; m_ovf24 <= 1'b0;
        m_rem   <= int'(len_i);
        m_phase <= (len_i == 8'd0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (prod_valid_i) begin
        m_sum17 <= step(m_sum17, pv, 17);
        m_sum24 <= step(m_sum24, pv, 24);
        m_ovf17 <= m_ovf17 | ovf_of(m_sum17, pv, 17);
        m_ovf24 <= m_ovf24 | ovf_of(m_sum24, pv, 24);
        m_rem   <= m_rem - 1;
        if (m_rem == 1) m_phase <= 2;
      end
    end else begin
      if (acc_ready_i) m_phase <= 0;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge sys_clk) begin
    logic [16:0] e17;
    logic [23:0] e24;
    if (chk_en) begin
      e17 = m_sum17[16:0];
      e24 = m_sum24[23:0];
      chk("w17_prod_ready", {63'd0, rdy17},  {63'd0, m_phase == 1});
      chk("w17_acc_valid",  {63'd0, vld17},  {63'd0, m_phase == 2});
      chk("w17_busy",       {63'd0, busy17}, {63'd0, m_phase != 0});
      chk("w17_ovf",        {63'd0, ovf17},  {63'd0, m_ovf17});
      chk("w17_acc",        {47'd0, acc17},  {47'd0, e17});
      chk("w24_prod_ready", {63'd0, rdy24},  {63'd0, m_phase == 1});
      chk("w24_acc_valid",  {63'd0, vld24},  {63'd0, m_phase == 2});
      chk("w24_busy",       {63'd0, busy24}, {63'd0, m_phase != 0});
      chk("w24_ovf",        {63'd0, ovf24},  {63'd0, m_ovf24});
      chk("w24_acc",        {40'd0, acc24},  {40'd0, e24});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] p);
    prod_valid_i = 1'b1;
    prod_i       = p;
    cyc();
    prod_valid_i = 1'b0;
  endtask

  task automatic start_burst(input logic [7:0] n);
    start_i = 1'b1;
    len_i   = n;
    cyc();
    start_i = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1; start_i = 1'b0; len_i = 8'd0; abort_i = 1'b0;
    prod_i = 16'd0; prod_valid_i = 1'b0; acc_ready_i = 1'b1;
    cyc(); cyc();
    chk("rst_acc_valid",  {63'd0, vld24},  64'd0);
    chk("rst_prod_ready", {63'd0, rdy24},  64'd0);
    chk("rst_busy",       {63'd0, busy24}, 64'd0);
    chk("rst_ovf",        {63'd0, ovf24},  64'd0);
    chk("rst_acc",        {40'd0, acc24},  64'd0);
    sys_rst = 1'b0;
    chk_en  = 1'b1;
    cyc();

    // 1: basic burst 100 - 20 + 7
    start_burst(8'd3);
    feed(16'd100); feed(-16'sd20); feed(16'd7);
    chk("t1_acc_valid", {63'd0, vld24}, 64'd1);
    chk("t1_acc",       {40'd0, acc24}, 64'd87);
    chk("t1_ovf",       {63'd0, ovf24}, 64'd0);
    cyc();
    chk("t1_busy_after", {63'd0, busy24}, 64'd0);

    // 2: backpressure on both sides
    acc_ready_i = 1'b0;
    start_burst(8'd2);
    feed(16'h7FFF);
    cyc(); cyc();
    feed(16'h0001);
    for (int i = 0; i < 4; i++) begin
      chk("t2_acc_valid_held", {63'd0, vld24}, 64'd1);
      chk("t2_acc_held",       {40'd0, acc24}, 64'd32768);
      cyc();
    end
    acc_ready_i = 1'b1;
    cyc();
    chk("t2_released", {63'd0, vld24}, 64'd0);

    // 3: zero-length burst
    start_burst(8'd0);
    chk("t3_acc_valid",  {63'd0, vld24}, 64'd1);
    chk("t3_acc",        {40'd0, acc24}, 64'd0);
    chk("t3_prod_ready", {63'd0, rdy24}, 64'd0);
    cyc();

    // 4: overflow at 17 bits, none at 24 bits
    acc_ready_i = 1'b0;
    start_burst(8'd3);
    feed(16'h7FFF); feed(16'h7FFF); feed(16'h7FFF);
`ifdef PROD_ACC_SAT_EN
    chk("t4_acc17", {47'd0, acc17}, 64'h0FFFF);
`else
    chk("t4_acc17", {47'd0, acc17}, 64'h17FFD);
`endif
    chk("t4_ovf17", {63'd0, ovf17}, 64'd1);
    chk("t4_acc24", {40'd0, acc24}, 64'd98301);
    chk("t4_ovf24", {63'd0, ovf24}, 64'd0);
    acc_ready_i = 1'b1;
    cyc();

    // 5: abort collides with a valid product
    start_burst(8'd2);
    abort_i = 1'b1; prod_valid_i = 1'b1; prod_i = 16'd9;
    cyc();
    abort_i = 1'b0; prod_valid_i = 1'b0;
    chk("t5_busy",       {63'd0, busy24}, 64'd0);
    chk("t5_prod_ready", {63'd0, rdy24},  64'd0);
    start_burst(8'd1);
    feed(16'd5);
    chk("t5_acc", {40'd0, acc24}, 64'd5);
    cyc();

    // 7: clamp/wrap then an opposite-signed product
    start_burst(8'd4);
    feed(16'h7FFF); feed(16'h7FFF); feed(16'h7FFF); feed(16'h8000);
    cyc();

    // 6: asynchronous reset while a negative-overflowed result waits
    acc_ready_i = 1'b0;
    start_burst(8'd3);
    feed(16'h8000); feed(16'h8000); feed(16'h8000);
    chk("t6_pre_valid", {63'd0, vld17}, 64'd1);
    chk("t6_pre_ovf",   {63'd0, ovf17}, 64'd1);
`ifdef PROD_ACC_SAT_EN
    chk("t6_pre_acc17", {47'd0, acc17}, 64'h10000);
`else
    chk("t6_pre_acc17", {47'd0, acc17}, 64'h08000);
`endif
    #2;
    sys_rst = 1'b1;
    #1;
    chk("t6_valid_async", {63'd0, vld17},  64'd0);
    chk("t6_busy_async",  {63'd0, busy17}, 64'd0);
    chk("t6_ovf_async",   {63'd0, ovf17},  64'd0);
    chk("t6_acc_async",   {47'd0, acc17},  64'd0);
    cyc();
    sys_rst = 1'b0;
    acc_ready_i = 1'b1;
    cyc();
    start_burst(8'd1);
    feed(-16'sd1);
    chk("t6_post_acc24", {40'd0, acc24}, 64'hFFFFFF);
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
